board_render_pipe: RTL

- Parametrised, pipelined successor to the combinational pixel colour generator for the Tetris VGA path.
- Board geometry, cell size and board-RAM read latency are parameters.
- Cell indices come from running counters instead of pixel-range compares.
- Adds a line-clear flash animation FSM and emits registered, latency-aligned RGB and sync to the DAC.

---
 rtl/board_render_if.sv | 25 ++
 rtl/board_render_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_render_if.sv
// Pixel-stream interface: raw video timing into the renderer, registered RGB and
// latency-aligned syncs back out toward the DAC.
interface board_render_if;
   logic       blank_n;
   logic       hsync_in;
   logic       vsync_in;
   logic [8:0] row;
   logic [9:0] column;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       hsync_out;
   logic       vsync_out;
   logic       blank_n_out;

   modport master (
      output blank_n, hsync_in, vsync_in, row, column,
      input  red, green, blue, hsync_out, vsync_out, blank_n_out
   );

   modport slave (
      input  blank_n, hsync_in, vsync_in, row, column,
      output red, green, blue, hsync_out, vsync_out, blank_n_out
   );
endinterface

// File: rtl/board_render_pipe.sv
// Pipelined Tetris board renderer with line-clear flash FSM; RGB/syncs appear RAM_LAT+1 clocks
// after row/column. Optional ghost piece rendering is enabled by BOARD_RENDER_GHOST_EN.
module board_render_pipe #(
   parameter int unsigned CELL         = 20,
   parameter int unsigned BOARD_X0     = 220,
   parameter int unsigned BOARD_Y0     = 40,
   parameter int unsigned COLS         = 10,
   parameter int unsigned ROWS         = 20,
   parameter int unsigned RAM_LAT      = 1,
   parameter int unsigned FLASH_FRAMES = 8,
   parameter int unsigned FLASH_COUNT  = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   board_render_if.slave                  vid,
   input  logic                           frame_tick,
   input  logic [2:0]                     q,
   input  logic [2:0]                     block,
   input  logic [15:0]                    piece_cx,
   input  logic [19:0]                    piece_cy,
   input  logic [4:0]                     ghost_drop,
   input  logic                           clear_start,
   input  logic [ROWS-1:0]                clear_rows,
   output logic                           clear_done,
   output logic                           flash_busy,
   output logic [$clog2(ROWS*COLS)-1:0]   ram_addr,
   input  logic [23:0]                    ram_color
);
   localparam int unsigned AW = $clog2(ROWS*COLS);
   localparam int unsigned SW = $clog2(CELL);
   localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);
   localparam int unsigned PW = $clog2(FLASH_COUNT + 1);
   localparam int Bx0 = int'(BOARD_X0);
   localparam int Bx1 = int'(BOARD_X0 + COLS * CELL);
   localparam int By0 = int'(BOARD_Y0);
   localparam int By1 = int'(BOARD_Y0 + ROWS * CELL);
   localparam int Cl  = int'(CELL);
   localparam logic [1:0] RgOther = 2'd0;
   localparam logic [1:0] RgFrame = 2'd1;
   localparam logic [1:0] RgBoard = 2'd2;
   localparam logic [23:0] Rose = 24'hFFCCE5;

   typedef struct packed {
      logic [1:0] region;
      logic       game;
      logic [2:0] blk;
      logic [4:0] cy;
      logic       hit;
      logic       ghost;
      logic       hs;
      logic       vs;
      logic       bl;
   } sb_t;

   localparam sb_t SbRst = '{region: RgOther, game: 1'b0, blk: 3'd0, cy: 5'd0, hit: 1'b0,
                             ghost: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0};

   typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} flash_st_e;

   logic [3:0]    cx_q, cx_d;
   logic [4:0]    cy_q, cy_d;
   logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [AW-1:0] addr_q, addr_d;
   sb_t           sb_d;
   sb_t           sb_q [RAM_LAT];
   sb_t           sb_last;
   int            col_i, row_i;
   logic          in_bx, in_by, in_fx, in_fy;

   flash_st_e       st_q, st_d;
   logic [FW-1:0]   frm_q, frm_d;
   logic [PW-1:0]   pair_q, pair_d;
   logic [ROWS-1:0] mask_q, mask_d;
   logic            done_q, done_d, busy_q, busy_d;

   logic [23:0] rgb_q, rgb_d;
   logic        hs_q, vs_q, bl_q;
   logic [31:0] mask_pad;

`ifdef BOARD_RENDER_GHOST_EN
   logic [5:0] gy;
`else
   logic unused_ghost;
   assign unused_ghost = ^ghost_drop;
`endif

   function automatic logic [23:0] palette(input logic [2:0] b);
      unique case (b)
         3'd7:    palette = 24'h99FFCC;
         3'd1:    palette = 24'h66B2FF;
         3'd2:    palette = 24'hFF3399;
         3'd3:    palette = 24'h7F00FF;
         3'd4:    palette = 24'hFFFF66;
         3'd5:    palette = 24'h66FF66;
         3'd6:    palette = 24'h990099;
         default: palette = Rose;
      endcase
   endfunction

   // Counters produce the cell index of the current pixel combinationally, so stage 0 sees it.
   always_comb begin
      col_i = int'(vid.column);
      row_i = int'(vid.row);
      cx_d  = cx_q;
      sx_d  = sx_q;
      cy_d  = cy_q;
      sy_d  = sy_q;
      in_bx = (col_i >= Bx0) && (col_i < Bx1);
      in_by = (row_i >= By0) && (row_i < By1);
      in_fx = (col_i >= Bx0 - Cl) && (col_i < Bx1 + Cl);
      in_fy = (row_i >= By0 - Cl) && (row_i < By1 + Cl);
      if (col_i == Bx0) begin
         cx_d = '0;
         sx_d = '0;
      end else if (in_bx) begin
         if (sx_q == SW'(CELL - 1)) begin
            sx_d = '0;
            cx_d = cx_q + 4'd1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
      end
      if (col_i == 0) begin
         if (row_i == By0) begin
            cy_d = '0;
            sy_d = '0;
         end else if (in_by) begin
            if (sy_q == SW'(CELL - 1)) begin
               sy_d = '0;
               cy_d = cy_q + 5'd1;
            end else begin
               sy_d = sy_q + 1'b1;
            end
         end
      end
      addr_d = AW'(int'(cy_d) * int'(COLS) + int'(cx_d));

      sb_d        = SbRst;
      sb_d.region = (in_bx && in_by) ? RgBoard : ((in_fx && in_fy) ? RgFrame : RgOther);
      sb_d.game   = (q == 3'b011) || (q == 3'b101);
      sb_d.blk    = block;
      sb_d.cy     = cy_d;
      sb_d.hs     = vid.hsync_in;
      sb_d.vs     = vid.vsync_in;
      sb_d.bl     = vid.blank_n;
`ifdef BOARD_RENDER_GHOST_EN
      gy = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         if (piece_cx[4*i +: 4] == cx_d && piece_cy[5*i +: 5] == cy_d) sb_d.hit = 1'b1;
`ifdef BOARD_RENDER_GHOST_EN
         gy = {1'b0, piece_cy[5*i +: 5]} + {1'b0, ghost_drop};
         if (ghost_drop != 5'd0 && gy < 6'(ROWS) && piece_cx[4*i +: 4] == cx_d &&
             gy == {1'b0, cy_d}) sb_d.ghost = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cx_q   <= '0;
         sx_q   <= '0;
         cy_q   <= '0;
         sy_q   <= '0;
         addr_q <= '0;
         for (int k = 0; k < int'(RAM_LAT); k++) sb_q[k] <= SbRst;
      end else begin
         cx_q    <= cx_d;
         sx_q    <= sx_d;
         cy_q    <= cy_d;
         sy_q    <= sy_d;
         addr_q  <= addr_d;
         sb_q[0] <= sb_d;
         for (int k = 1; k < int'(RAM_LAT); k++) sb_q[k] <= sb_q[k-1];
      end
   end

   // Flash FSM: IDLE ignores frame ticks, so a tick coinciding with clear_start is not counted.
   always_comb begin
      st_d   = st_q;
      frm_d  = frm_q;
      pair_d = pair_q;
      mask_d = mask_q;
      busy_d = busy_q;
      done_d = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (clear_start) begin
               st_d   = StOn;
               mask_d = clear_rows;
               frm_d  = '0;
               pair_d = '0;
               busy_d = 1'b1;
            end
         end
         StOn: begin
            if (frame_tick) begin
               if (frm_q == FW'(FLASH_FRAMES - 1)) begin
                  frm_d = '0;
                  st_d  = StOff;
               end else begin
                  frm_d = frm_q + 1'b1;
               end
            end
         end
         StOff: begin
            if (frame_tick) begin
               if (frm_q == FW'(FLASH_FRAMES - 1)) begin
                  frm_d = '0;
                  if (pair_q == PW'(FLASH_COUNT - 1)) begin
                     st_d   = StDone;
                     done_d = 1'b1;
                  end else begin
                     pair_d = pair_q + 1'b1;
                     st_d   = StOn;
                  end
               end else begin
                  frm_d = frm_q + 1'b1;
               end
            end
         end
         StDone: begin
            st_d   = StIdle;
            busy_d = 1'b0;
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q   <= StIdle;
         frm_q  <= '0;
         pair_q <= '0;
         mask_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         frm_q  <= frm_d;
         pair_q <= pair_d;
         mask_q <= mask_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   assign sb_last  = sb_q[RAM_LAT-1];
   assign mask_pad = 32'(mask_q);

   always_comb begin
      rgb_d = 24'h606060;
      if (!sb_last.bl) begin
         rgb_d = 24'h000000;
      end else if (sb_last.region == RgBoard) begin
         if (!sb_last.game)                         rgb_d = Rose;
         else if (st_q == StOn && mask_pad[sb_last.cy]) rgb_d = 24'hFFFFFF;
         else if (sb_last.hit)                      rgb_d = palette(sb_last.blk);
`ifdef BOARD_RENDER_GHOST_EN
         else if (sb_last.ghost)                    rgb_d = 24'h606060;
`endif
         else if (ram_color != 24'd0)               rgb_d = ram_color;
         else                                       rgb_d = Rose;
      end else if (sb_last.region == RgFrame) begin
         rgb_d = 24'hA0A0A0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         bl_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= sb_last.hs;
         vs_q  <= sb_last.vs;
         bl_q  <= sb_last.bl;
      end
   end

   assign vid.red         = rgb_q[23:16];
   assign vid.green       = rgb_q[15:8];
   assign vid.blue        = rgb_q[7:0];
   assign vid.hsync_out   = hs_q;
   assign vid.vsync_out   = vs_q;
   assign vid.blank_n_out = bl_q;
   assign ram_addr        = addr_q;
   assign clear_done      = done_q;
   assign flash_busy      = busy_q;
endmodule
